// File: rtl/nmsedec_pass_accum_pkg.sv
// Shared constants, pass encodings, FSM state type and the saturating add
// used by the per-pass NMSEDEC distortion accumulator.
package nmsedec_pass_accum_pkg;

  localparam int NMSE_W  = 13;
  localparam int ACC_W   = 26;
  localparam int N_LANES = 3;

  localparam logic [1:0] PASS_SP  = 2'd0;
  localparam logic [1:0] PASS_MRP = 2'd1;
  localparam logic [1:0] PASS_CP  = 2'd2;
  localparam logic [1:0] PASS_ILL = 2'd3;

  // Largest positive value of a signed ACC_W reading; sums never exceed it.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [NMSE_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W+1-NMSE_W){1'b0}}, b};
    return (s > {1'b0, ACC_MAX}) ? ACC_MAX : s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/nmsedec_pass_accum_if.sv
// Coder-side contribution stream plus the published per-pass sums handed to
// the pass error calculator.
interface nmsedec_pass_accum_if;
  import nmsedec_pass_accum_pkg::*;

  logic              clk_pass_cal;
  logic              cb_start;
  logic [3:0]        msb_bp;
  logic [3:0]        weight_in;
  logic              nmse_vld;
  logic [1:0]        nmse_pass;
  logic [NMSE_W-1:0] nmse_val;
  logic              bp_done;
  logic              cb_done;
  logic [ACC_W-1:0]  bit_nmsedec_sp;
  logic [ACC_W-1:0]  bit_nmsedec_mrp;
  logic [ACC_W-1:0]  bit_nmsedec_cp;
  logic [3:0]        mul_factor_error_reg;
  logic [3:0]        count_bp_delay_b_reg;
  logic              cal_out_vld;
  logic              ovf_err;
  logic              pass_err;

  modport master (
    output clk_pass_cal, cb_start, msb_bp, weight_in, nmse_vld, nmse_pass,
           nmse_val, bp_done, cb_done,
    input  bit_nmsedec_sp, bit_nmsedec_mrp, bit_nmsedec_cp,
           mul_factor_error_reg, count_bp_delay_b_reg, cal_out_vld, ovf_err,
           pass_err
  );

  modport slave (
    input  clk_pass_cal, cb_start, msb_bp, weight_in, nmse_vld, nmse_pass,
           nmse_val, bp_done, cb_done,
    output bit_nmsedec_sp, bit_nmsedec_mrp, bit_nmsedec_cp,
           mul_factor_error_reg, count_bp_delay_b_reg, cal_out_vld, ovf_err,
           pass_err
  );

endinterface

// File: rtl/nmsedec_acc_lane.sv
// One saturating accumulator lane. sum_with_sample already includes the
// sample of the current cycle so a publish in that cycle captures it.
module nmsedec_acc_lane
  import nmsedec_pass_accum_pkg::*;
(
  input  logic              clk_pass_pre,
  input  logic              rst,
  input  logic              rst_syn,
  input  logic              clr,
  input  logic              add_en,
  input  logic [NMSE_W-1:0] add_val,
  output logic [ACC_W-1:0]  sum_with_sample
);

  logic [ACC_W-1:0] acc_reg;

  assign sum_with_sample = add_en ? sat_add(acc_reg, add_val) : acc_reg;

  always_ff @(posedge clk_pass_pre or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
    end else if (rst_syn || clr) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= sum_with_sample;
    end
  end

endmodule

// File: rtl/nmsedec_pass_accum.sv
// Per-pass NMSEDEC accumulator: sums SP/MRP/CP contributions per bit-plane
// and holds the published sums until the pass error calculator captures them.
module nmsedec_pass_accum
  import nmsedec_pass_accum_pkg::*;
(
  input logic                 clk_pass_pre,
  input logic                 rst,
  input logic                 rst_syn,
  nmsedec_pass_accum_if.slave bus
);

  state_t                          state_reg;
  logic [3:0]                      bp_cnt_reg;
  logic [3:0]                      weight_reg;
  logic [3:0]                      mul_reg;
  logic [3:0]                      bp_out_reg;
  logic [N_LANES-1:0][ACC_W-1:0]   out_reg;
  logic                            cal_sync_reg;
  logic                            vld_reg;
  logic                            ovf_reg;
  logic                            perr_reg;

  logic                            in_accum;
  logic                            cal_pos;
  logic                            capture;
  logic                            publish;
  logic                            sample_ok;
  logic                            lane_clr;
  logic [N_LANES-1:0]              lane_add;
  logic [N_LANES-1:0][ACC_W-1:0]   lane_sum;

  assign in_accum  = (state_reg == ACCUM);
  assign cal_pos   = bus.clk_pass_cal & ~cal_sync_reg;
  assign capture   = cal_pos & vld_reg;
  // A restart wins over everything else arriving in the same cycle.
  assign publish   = in_accum & bus.bp_done & ~bus.cb_start;
  assign sample_ok = in_accum & bus.nmse_vld & ~bus.cb_start;
  assign lane_clr  = bus.cb_start | publish;

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign lane_add[gi] = sample_ok && (bus.nmse_pass == 2'(gi));

      nmsedec_acc_lane u_lane (
        .clk_pass_pre    (clk_pass_pre),
        .rst             (rst),
        .rst_syn         (rst_syn),
        .clr             (lane_clr),
        .add_en          (lane_add[gi]),
        .add_val         (bus.nmse_val),
        .sum_with_sample (lane_sum[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_pass_pre or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bp_cnt_reg   <= '0;
      weight_reg   <= '0;
      mul_reg      <= '0;
      bp_out_reg   <= '0;
      out_reg      <= '0;
      cal_sync_reg <= 1'b0;
      vld_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      perr_reg     <= 1'b0;
    end else if (rst_syn) begin
      state_reg    <= IDLE;
      bp_cnt_reg   <= '0;
      weight_reg   <= '0;
      mul_reg      <= '0;
      bp_out_reg   <= '0;
      out_reg      <= '0;
      cal_sync_reg <= 1'b0;
      vld_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      perr_reg     <= 1'b0;
    end else begin
      cal_sync_reg <= bus.clk_pass_cal;

      if (in_accum && bus.nmse_vld && (bus.nmse_pass == PASS_ILL)) begin
        perr_reg <= 1'b1;
      end

      if (bus.cb_start) begin
        state_reg  <= ACCUM;
        bp_cnt_reg <= bus.msb_bp;
        weight_reg <= bus.weight_in;
      end else if (in_accum && bus.cb_done) begin
        state_reg <= IDLE;
      end

      // A capture in the publish cycle hands over the old data, so the new
      // data stays valid without flagging an overwrite.
      if (publish) begin
        out_reg    <= lane_sum;
        mul_reg    <= weight_reg;
        bp_out_reg <= bp_cnt_reg;
        vld_reg    <= 1'b1;
        if (vld_reg && !capture) begin
          ovf_reg <= 1'b1;
        end
        if (bp_cnt_reg != 4'd0) begin
          bp_cnt_reg <= bp_cnt_reg - 4'd1;
        end
      end else if (capture) begin
        vld_reg <= 1'b0;
      end
    end
  end

  assign bus.bit_nmsedec_sp       = out_reg[PASS_SP];
  assign bus.bit_nmsedec_mrp      = out_reg[PASS_MRP];
  assign bus.bit_nmsedec_cp       = out_reg[PASS_CP];
  assign bus.mul_factor_error_reg = mul_reg;
  assign bus.count_bp_delay_b_reg = bp_out_reg;
  assign bus.cal_out_vld          = vld_reg;
  assign bus.ovf_err              = ovf_reg;
  assign bus.pass_err             = perr_reg;

endmodule

// File: doc/nmsedec_pass_accum.md
# nmsedec_pass_accum

Per-pass distortion accumulator directly upstream of the pass error calculator. During each bit-plane it sums the per-coefficient NMSEDEC contributions emitted by the bit-plane coder, one sum each for significance propagation (SP), magnitude refinement (MRP) and cleanup (CP). At each bit-plane boundary it publishes the three 26-bit sums together with the subband weight factor and the bit-plane index. The values are held with `cal_out_vld` until the downstream stage captures them on a `clk_pass_cal` rising edge.

## Interface
Parameters:
- NMSE_W, 13, width of one coefficient's NMSEDEC contribution (unsigned).
- ACC_W, 26, accumulator/output width; outputs are read downstream as signed, so the value is kept non-negative.

Ports:
- clk_pass_pre  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rst_syn  in  1  synchronous clear, same effect as rst.
- clk_pass_cal  in  1  slow capture strobe from the pass controller; level signal, sampled in the clk_pass_pre domain.
- cb_start  in  1  one-cycle pulse; a new code-block begins.
- msb_bp  in  4  first (most significant) bit-plane index, latched at cb_start.
- weight_in  in  4  subband weight factor, latched at cb_start.
- nmse_vld  in  1  contribution valid.
- nmse_pass  in  2  pass of the contribution: 0 = SP, 1 = MRP, 2 = CP, 3 = illegal.
- nmse_val  in  NMSE_W  contribution value.
- bp_done  in  1  one-cycle pulse; the current bit-plane's three passes are finished.
- cb_done  in  1  one-cycle pulse; the code-block is finished.
- bit_nmsedec_sp / _mrp / _cp  out  ACC_W  published per-pass sums.
- mul_factor_error_reg  out  4  published weight.
- count_bp_delay_b_reg  out  4  bit-plane index of the published sums.
- cal_out_vld  out  1  published data valid.
- ovf_err  out  1  sticky: an unconsumed result was overwritten.
- pass_err  out  1  sticky: nmse_pass = 3 was seen.

## Operation
- The FSM has two states:
  - IDLE → ACCUM on cb_start. On this transition, clear all three accumulators, load bp_cnt = msb_bp, and latch the weight.
  - ACCUM → IDLE on cb_done.
- cb_start in ACCUM restarts the code-block (same actions as IDLE → ACCUM). cb_start takes priority over cb_done in the same cycle.
- Accumulation happens in ACCUM only.
  - When nmse_vld = 1, add nmse_val to the lane selected by nmse_pass.
  - Each lane saturates at 2^(ACC_W-1)-1 (0x1FFFFFF) and never wraps.
  - nmse_pass = 3: the sample is dropped and pass_err is set.
  - nmse_vld outside ACCUM is ignored.
- Publish happens on bp_done in ACCUM.
  - Copy the three sums into the output registers. A sample valid in the same cycle is included in the published sum.
  - Copy the weight to mul_factor_error_reg and bp_cnt to count_bp_delay_b_reg.
  - Set cal_out_vld, clear the accumulators, and decrement bp_cnt, saturating at 0.
- Consume rule:
  - cal_sync is clk_pass_cal registered once.
  - cal_pos = clk_pass_cal & ~cal_sync.
  - A cycle with cal_pos = 1 and cal_out_vld = 1 is the capture cycle. cal_out_vld clears on the next edge unless a publish happens in that same cycle; in that case it stays 1 with the new data.
- Overwrite: a publish while cal_out_vld = 1 with no capture in that cycle overwrites the outputs and sets ovf_err.
- cb_done with sums pending (no bp_done) discards them and publishes nothing.
- Output registers hold their value until the next publish or reset.

## Timing
- All outputs, flags and internal state reset to 0 (rst or rst_syn). bp_cnt resets to 0 and the FSM to IDLE.
- Publish latency: bp_done at edge t makes the outputs and cal_out_vld valid after edge t+1.
- Accumulate latency: a sample at edge t is visible in the lane after edge t+1.
- Capture latency: cal_pos asserts one clk_pass_pre cycle after clk_pass_cal rises. cal_out_vld drops one cycle after cal_pos.
- rst_syn mid-block returns the FSM to IDLE and cal_out_vld to 0 on the next edge.
- Throughput: one contribution per cycle, back-to-back, including the bp_done cycle.

## Structure
- Shared package holds:
  - NMSE_W = 13 and ACC_W = 26.
  - Pass encodings PASS_SP = 2'd0, PASS_MRP = 2'd1, PASS_CP = 2'd2.
  - The FSM state typedef {IDLE, ACCUM}.
  - The saturation constant ACC_MAX.
- Sub-module `nmsedec_acc_lane`: one saturating accumulator with add-enable, clear and read-out. Instantiate it three times.
- The top level contains the FSM, bp_cnt, the edge detect, the output registers and the flags.

## Test plan
- Basic publish:
  - Stimulus: cb_start (msb_bp = 9, weight_in = 5); SP values 10, 20; MRP 7; CP 100; then bp_done.
  - Required response: sp = 30, mrp = 7, cp = 100, mul_factor_error_reg = 5, count_bp_delay_b_reg = 9, cal_out_vld = 1 one cycle after bp_done.
- Consume:
  - Stimulus: raise clk_pass_cal while cal_out_vld = 1.
  - Required response: cal_out_vld = 0 two cycles after the rise; data unchanged. A second bit-plane publishes count_bp_delay_b_reg = 8.
- Saturation:
  - Stimulus: 5000 CP samples of 0x1FFF.
  - Required response: cp = 0x1FFFFFF, never wraps negative.
- Same-cycle events:
  - Stimulus: sample 42 on MRP coincident with bp_done.
  - Required response: 42 is included in the published mrp and the next bit-plane's mrp starts at 0.
  - Stimulus: publish coincident with a capture.
  - Required response: cal_out_vld stays 1 with the new data and ovf_err stays 0.
- Overwrite/illegal:
  - Stimulus: two bp_done with no clk_pass_cal rise between them.
  - Required response: ovf_err = 1; outputs show the second sums.
  - Stimulus: nmse_pass = 3.
  - Required response: pass_err = 1, all lanes unchanged.
- Resets:
  - Stimulus: rst_syn mid-ACCUM with non-zero sums and cal_out_vld = 1.
  - Required response: next cycle all outputs = 0 and FSM in IDLE.
  - Stimulus: asynchronous rst low.
  - Required response: outputs clear immediately, without a clock.
